// File: rtl/single_cycle_mem_pkg.sv
// Shared types and constants for the single-outstanding memory bus arbiter.
package single_cycle_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} arb_owner_e;

  // Wide enough for DATA_W up to 512; users slice the low BE_W bits.
  localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/single_cycle_arb_prio.sv
// Owner select: data wins unless fetch is pending and has hit the starvation limit.
module single_cycle_arb_prio
  import single_cycle_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       starved,
  output arb_owner_e owner,
  output logic       any_req
);

  assign owner   = (d_req && !(if_req && starved)) ? OWN_D : OWN_I;
  assign any_req = if_req | d_req;

endmodule

// File: rtl/single_cycle_mem_arbiter.sv
// Shares one memory bus between fetch and load/store ports, one transaction in flight,
// data priority with a saturating starvation counter that forces a fetch grant.
module single_cycle_mem_arbiter
  import single_cycle_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BE_W-1:0]   bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  localparam int             CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_nxt;
  arb_owner_e       owner;
  logic             any_req;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_MAX);

  single_cycle_arb_prio u_prio (
    .if_req  (if_req),
    .d_req   (d_req),
    .starved (starved),
    .owner   (owner),
    .any_req (any_req)
  );

  // NOTE: state lives in flops with async reset and non-blocking updates only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:           if (if_gnt)     state_nxt = WAIT_I;
                      else if (d_gnt) state_nxt = WAIT_D;
      WAIT_I, WAIT_D: if (bus_rvalid) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_be    = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    busy      = 1'b0;
    // The bus payload is combinational from the request ports, so it is gated during reset.
    if (rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: if (any_req) begin
          bus_req = 1'b1;
          if (owner == OWN_D) begin
            bus_we    = d_we;
            bus_be    = d_be;
            bus_addr  = d_addr;
            bus_wdata = d_wdata;
            d_gnt     = bus_gnt;
          end else begin
            bus_be   = BE_ALL[BE_W-1:0];
            bus_addr = if_addr;
            if_gnt   = bus_gnt;
          end
        end
        WAIT_I: if (bus_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = bus_rdata;
        end
        WAIT_D: if (bus_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = bus_rdata;
        end
        default: ;
      endcase
    end
  end

  // Counts data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        starve_cnt <= '0;
    else if (!if_req || if_gnt)      starve_cnt <= '0;
    else if (d_gnt && !starved)      starve_cnt <= starve_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_single_cycle_mem_arbiter.sv
// Self-checking bench for single_cycle_mem_arbiter: per-scenario tasks plus a response scoreboard.
module tb_single_cycle_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        port;   // 1 = data, 0 = fetch
    logic        chk;    // compare rdata (loads/fetches only)
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  single_cycle_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [138:0] all_outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                           bus_req, bus_we, bus_be, bus_addr, bus_wdata, busy};

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_rvalid || d_rvalid) begin
      total++;
      if (exp_q.size() == 0 || (if_rvalid && d_rvalid)) begin
        bad++;
        $display("FAIL resp_unexpected: if_rvalid=%0b d_rvalid=%0b, required a pending expectation on one port",
                 if_rvalid, d_rvalid);
      end else begin
        exp_t e;
        logic ok;
        e = exp_q.pop_front();
        if (e.port) ok = d_rvalid && (!e.chk || d_rdata === e.data) && if_rdata === 32'h0;
        else        ok = if_rvalid && if_rdata === e.data && d_rdata === 32'h0;
        if (!ok) begin
          bad++;
          $display("FAIL resp_match: got if_rvalid=%0b if_rdata=%h d_rvalid=%0b d_rdata=%h, required port=%0s data=%h",
                   if_rvalid, if_rdata, d_rvalid, d_rdata, e.port ? "data" : "fetch", e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h88; d_wdata = 32'h1234_5678;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    #3;
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL reset_outs: got %h, required 0", all_outs);
    end
    step();
    idle_inputs();
    rst = 1;
    // Put the arbiter into WAIT_D, then reset it mid-transaction.
    step();
    d_req = 1; d_addr = 32'h3000; bus_gnt = 1;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL reset_pre_gnt: got d_gnt=%0b if_gnt=%0b, required 1/0", d_gnt, if_gnt);
    end
    step();
    d_req = 0; bus_gnt = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_pre_busy: got %0b, required 1", busy);
    end
    #2;
    rst = 0;
    if_req = 1; if_addr = 32'h44; d_req = 1; bus_gnt = 1;
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL reset_mid_outs: got %h, required 0", all_outs);
    end
    step();
    idle_inputs();
    rst = 1;
    step();
    bus_rvalid = 1; bus_rdata = 32'h0000_1234;
    @(negedge clk);
    total++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || if_rvalid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_drop: got d_rvalid=%0b d_rdata=%h if_rvalid=%0b busy=%0b, required all 0",
                      d_rvalid, d_rdata, if_rvalid, busy);
    end
    step();
    bus_rvalid = 0;
  endtask

  task automatic test_single_fetch();
    step();
    if_req = 1; if_addr = 32'h100; bus_gnt = 1;
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt, bus_req, bus_we, bus_be, bus_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100}) begin
      bad++; $display("FAIL fetch_gnt: got if_gnt=%0b d_gnt=%0b req=%0b we=%0b be=%h addr=%h, required 1 0 1 0 f 00000100",
                      if_gnt, d_gnt, bus_req, bus_we, bus_be, bus_addr);
    end
    exp_q.push_back('{port: 1'b0, chk: 1'b1, data: 32'h0050_0093});
    step();
    if_req = 0; bus_gnt = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus_req !== 1'b0) begin
      bad++; $display("FAIL fetch_wait: got busy=%0b bus_req=%0b, required 1/0", busy, bus_req);
    end
    step();
    bus_rvalid = 1; bus_rdata = 32'h0050_0093;
    step();
    bus_rvalid = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL fetch_idle: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_contention();
    step();
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h1000; bus_gnt = 1;
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt} !== 2'b01 || bus_addr !== 32'h1000) begin
      bad++; $display("FAIL cont_first: got if_gnt/d_gnt=%b addr=%h, required 01 00001000", {if_gnt, d_gnt}, bus_addr);
    end
    exp_q.push_back('{port: 1'b1, chk: 1'b1, data: 32'hD000_1000});
    step();
    d_req = 0; bus_rvalid = 1; bus_rdata = 32'hD000_1000;
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      bad++; $display("FAIL cont_wait: got if_gnt/d_gnt=%b, required 00", {if_gnt, d_gnt});
    end
    step();
    bus_rvalid = 0;
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt} !== 2'b10 || bus_addr !== 32'h200) begin
      bad++; $display("FAIL cont_second: got if_gnt/d_gnt=%b addr=%h, required 10 00000200", {if_gnt, d_gnt}, bus_addr);
    end
    exp_q.push_back('{port: 1'b0, chk: 1'b1, data: 32'h1111_0200});
    step();
    if_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h1111_0200;
    step();
    bus_rvalid = 0;
  endtask

  task automatic test_starvation();
    logic [1:0] seq [6];
    logic [1:0] exp_gnt;
    seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    step();
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    bus_gnt = 1; bus_rvalid = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      bus_rdata = 32'hCAFE_0000 + 32'(i);
      @(negedge clk);
      exp_gnt = (i % 2 == 0) ? seq[i / 2] : 2'b00;
      total++;
      if ({if_gnt, d_gnt} !== exp_gnt) begin
        bad++; $display("FAIL starve_cycle%0d: got if_gnt/d_gnt=%b, required %b", i, {if_gnt, d_gnt}, exp_gnt);
      end
      if (exp_gnt != 2'b00)
        exp_q.push_back('{port: exp_gnt[0], chk: 1'b1, data: 32'hCAFE_0000 + 32'(i + 1)});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_store();
    step();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; bus_gnt = 1;
    @(negedge clk);
    total++;
    if ({d_gnt, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL store_bus: got gnt=%0b req=%0b we=%0b be=%b addr=%h wdata=%h, required 1 1 1 0011 00002004 deadbeef",
                      d_gnt, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
    end
    exp_q.push_back('{port: 1'b1, chk: 1'b0, data: 32'h0});
    step();
    idle_inputs();
    step();
    bus_rvalid = 1; bus_rdata = 32'h5555_AAAA;
    step();
    bus_rvalid = 0;
  endtask

  task automatic test_backpressure();
    step();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4008; bus_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      total++;
      if ({if_gnt, d_gnt, bus_req, bus_we, bus_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h4008}) begin
        bad++; $display("FAIL bp_hold%0d: got if_gnt=%0b d_gnt=%0b req=%0b we=%0b addr=%h, required 0 0 1 0 00004008",
                        i, if_gnt, d_gnt, bus_req, bus_we, bus_addr);
      end
    end
    step();
    bus_gnt = 1;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL bp_gnt: got d_gnt=%0b if_gnt=%0b, required 1/0", d_gnt, if_gnt);
    end
    exp_q.push_back('{port: 1'b1, chk: 1'b1, data: 32'h0BAD_F00D});
    step();
    idle_inputs();
    bus_rvalid = 1; bus_rdata = 32'h0BAD_F00D;
    step();
    bus_rvalid = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_store();
    test_backpressure();
    step();
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL pending_resp: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
